tl_phase_timer: RTL and testbench

Phase sequencer and dwell timer for the traffic-light controller. Holds the 2-bit phase `state` and counts dwell time per phase on a prescaled tick. Flags expiry on `full` and synchronises the raw side-street car sensor to `c`. Consumes the `mode`/`delay` decision returned by the downstream mode-decision logic and drives the six lamp outputs.

---
 rtl/tl_phase_timer.sv | 170 +++++++++++++++++
 tb/tb_tl_phase_timer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_phase_timer.sv
// -----------------------------------------------------------------------------
// tl_phase_timer
//
// Phase sequencer and dwell timer for the traffic-light controller.
// A free-running prescaler produces a one-cycle tick every CLK_DIV clocks.
// The dwell counter advances on ticks. When it reaches the limit of the current
// phase, `full` is raised and the downstream mode logic chooses one of three
// actions: advance, extend once, or hold.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset (async assert, sync release)
//   car_raw   asynchronous side-street car sensor
//   mode      1 = advance allowed at expiry, 0 = hold phase
//   delay     1 = grant one extension of the current phase at expiry
//   night     (only with TL_NIGHT_EN) asynchronous night-mode request
//   state     current phase: 00 main G, 01 main Y, 10 side G, 11 side Y
//   full      dwell expired for the current phase (combinational)
//   c         synchronised car sensor
//   main_rgy  main lamps {red,yellow,green}
//   side_rgy  side lamps {red,yellow,green}
//
// Optional feature: define TL_NIGHT_EN to add the `night` input.
// -----------------------------------------------------------------------------
module tl_phase_timer #(
    parameter int CLK_DIV = 50000000,
    parameter int T_MG    = 30,
    parameter int T_MY    = 4,
    parameter int T_SG    = 15,
    parameter int T_SY    = 4,
    parameter int CW      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       car_raw,
    input  logic       mode,
    input  logic       delay,
`ifdef TL_NIGHT_EN
    input  logic       night,
`endif
    output logic [1:0] state,
    output logic       full,
    output logic       c,
    output logic [2:0] main_rgy,
    output logic [2:0] side_rgy
);

    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    logic [PW-1:0] presc_q, presc_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic          ext_q, ext_d;
    logic          s1_q, c_q;
    logic          tick;
    logic          full_raw;
    logic [CW-1:0] lim;

`ifdef TL_NIGHT_EN
    logic          night_s1_q, night_q;
    logic          blink_q, blink_d;
`endif

    assign tick = (presc_q == PW'(CLK_DIV - 1));

    always_comb begin
        lim = CW'(T_MG);
        case (state_q)
            2'b00:   lim = CW'(T_MG);
            2'b01:   lim = CW'(T_MY);
            2'b10:   lim = CW'(T_SG);
            default: lim = CW'(T_SY);
        endcase
    end

    assign full_raw = (cnt_q == lim - CW'(1));

    always_comb begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        if (tick) begin
            if (!full_raw) begin
                cnt_d = cnt_q + CW'(1);
            end else if (ext_q) begin
                // The single extension already ran: advance regardless of
                // what the mode logic asks for.
                state_d = state_q + 2'd1;
                cnt_d   = '0;
                ext_d   = 1'b0;
            end else if (delay) begin
                cnt_d = '0;
                ext_d = 1'b1;
            end else if (mode) begin
                state_d = state_q + 2'd1;
                cnt_d   = '0;
            end
            // mode=0: hold with the counter parked at lim-1, keeping full set.
        end
`ifdef TL_NIGHT_EN
        blink_d = 1'b0;
        if (night_q) begin
            state_d = 2'b00;
            cnt_d   = '0;
            ext_d   = 1'b0;
            blink_d = tick ? ~blink_q : blink_q;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            cnt_q   <= '0;
            state_q <= 2'b00;
            ext_q   <= 1'b0;
            s1_q    <= 1'b0;
            c_q     <= 1'b0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            ext_q   <= ext_d;
            s1_q    <= car_raw;
            c_q     <= s1_q;
        end
    end

`ifdef TL_NIGHT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            night_s1_q <= 1'b0;
            night_q    <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            night_s1_q <= night;
            night_q    <= night_s1_q;
            blink_q    <= blink_d;
        end
    end
`endif

    assign state = state_q;
    assign c     = c_q;

    always_comb begin
        main_rgy = 3'b001;
        side_rgy = 3'b100;
        case (state_q)
            2'b00:   begin main_rgy = 3'b001; side_rgy = 3'b100; end
            2'b01:   begin main_rgy = 3'b010; side_rgy = 3'b100; end
            2'b10:   begin main_rgy = 3'b100; side_rgy = 3'b001; end
            default: begin main_rgy = 3'b100; side_rgy = 3'b010; end
        endcase
`ifdef TL_NIGHT_EN
        if (night_q) begin
            main_rgy = {1'b0, blink_q, 1'b0};
            side_rgy = {1'b0, blink_q, 1'b0};
        end
`endif
    end

`ifdef TL_NIGHT_EN
    assign full = full_raw & ~night_q;
`else
    assign full = full_raw;
`endif

endmodule

// File: tb/tb_tl_phase_timer.sv
// -----------------------------------------------------------------------------
// tb_tl_phase_timer
//
// Self-checking bench for tl_phase_timer with CLK_DIV=4, T_MG=5, T_MY=2,
// T_SG=3, T_SY=2. A behavioural model tracks elapsed clocks, phase, elapsed
// ticks and the extension grant, and predicts every output cycle by cycle.
// -----------------------------------------------------------------------------
module tb_tl_phase_timer;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       car_raw = 1'b0;
    logic       mode = 1'b1;
    logic       delay = 1'b0;
    logic [1:0] state;
    logic       full;
    logic       c;
    logic [2:0] main_rgy;
    logic [2:0] side_rgy;
`ifdef TL_NIGHT_EN
    logic       night = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tl_phase_timer #(
        .CLK_DIV(CLK_DIV), .T_MG(5), .T_MY(2), .T_SG(3), .T_SY(2), .CW(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .car_raw(car_raw), .mode(mode), .delay(delay),
`ifdef TL_NIGHT_EN
        .night(night),
`endif
        .state(state), .full(full), .c(c), .main_rgy(main_rgy), .side_rgy(side_rgy)
    );

    // ---------------- reference model ----------------
    int         dwell  [4] = '{5, 2, 3, 2};
    logic [2:0] main_l [4] = '{3'b001, 3'b010, 3'b100, 3'b100};
    logic [2:0] side_l [4] = '{3'b100, 3'b100, 3'b001, 3'b010};

    int   m_clk;      // clocks since reset, modulo CLK_DIV
    int   m_phase;
    int   m_elapsed;  // ticks spent in the current dwell
    bit   m_ext;
    logic m_s1, m_c;

    function automatic bit m_full();
        return m_elapsed == dwell[m_phase] - 1;
    endfunction

    function automatic logic [9:0] exp_vec();
        logic [1:0] p;
        p = 2'(m_phase);
        return {p, m_full(), m_c, main_l[m_phase], side_l[m_phase]};
    endfunction

    function automatic logic [9:0] dut_vec();
        return {state, full, c, main_rgy, side_rgy};
    endfunction

    task automatic model_reset();
        m_clk = 0; m_phase = 0; m_elapsed = 0; m_ext = 0; m_s1 = 0; m_c = 0;
    endtask

    // Advance the model by one clock using the inputs about to be sampled,
    // then let the DUT take the same edge and settle.
    task automatic step();
        bit is_tick;
        is_tick = (m_clk == CLK_DIV - 1);
        m_clk   = (m_clk + 1) % CLK_DIV;
        if (is_tick) begin
            if (!m_full()) m_elapsed++;
            else if (m_ext) begin m_phase = (m_phase + 1) % 4; m_elapsed = 0; m_ext = 0; end
            else if (delay) begin m_elapsed = 0; m_ext = 1; end
            else if (mode)  begin m_phase = (m_phase + 1) % 4; m_elapsed = 0; end
        end
        m_c  = m_s1;
        m_s1 = car_raw;
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_async got=%b want=%b", dut_vec(), exp_vec());
        end
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL reset_held got=%b want=%b", dut_vec(), exp_vec());
        end
        #1 rst_n = 1'b1;
        $display("[TB] reset released, outputs %b", dut_vec());
    endtask

    // Called directly after reset release: measures each phase duration and
    // how many clocks full is high at the end of each phase.
    task automatic test_normal_cycle();
        int n, nf;
        mode = 1'b1; delay = 1'b0;
        for (int p = 0; p < 4; p++) begin
            n = 0;
            nf = full ? 1 : 0;
            while (n < 100) begin
                step();
                n++;
                tests++;
                if (dut_vec() !== exp_vec()) begin
                    fails++;
                    $display("FAIL normal_vec p=%0d got=%b want=%b", p, dut_vec(), exp_vec());
                end
                if (state != 2'(p)) break;
                if (full) nf++;
            end
            tests++;
            if (n != dwell[p] * CLK_DIV) begin
                fails++;
                $display("FAIL phase_len p=%0d got=%0d want=%0d", p, n, dwell[p] * CLK_DIV);
            end
            tests++;
            if (nf != CLK_DIV) begin
                fails++;
                $display("FAIL full_len p=%0d got=%0d want=%0d", p, nf, CLK_DIV);
            end
            $display("[TB] phase %0d lasted %0d clocks, full for %0d", p, n, nf);
        end
    endtask

    task automatic test_hold();
        int n;
        mode = 1'b1; delay = 1'b0;
        n = 0;
        while (!(m_phase == 0 && m_full()) && n < 200) begin step(); n++; end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL hold_wait got=timeout want=phase0_full");
        end
        mode = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            tests++;
            if (dut_vec() !== exp_vec() || state !== 2'b00 || full !== 1'b1) begin
                fails++;
                $display("FAIL hold_vec i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        mode = 1'b1;
        n = 0;
        while (state == 2'b00 && n < 20) begin
            step(); n++;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL hold_release got=%b want=%b", dut_vec(), exp_vec());
            end
        end
        tests++;
        if (state !== 2'b01 || n > CLK_DIV) begin
            fails++;
            $display("FAIL hold_advance got=state%b after %0d want=state01 within %0d",
                     state, n, CLK_DIV);
        end
        $display("[TB] hold released, advanced after %0d clocks", n);
    endtask

    task automatic test_extension();
        int n, in2;
        bit seen;
        mode = 1'b1;
        n = 0; in2 = 0; seen = 0;
        while (n < 300) begin
            delay = (m_phase == 2);
            step(); n++;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL ext_vec got=%b want=%b", dut_vec(), exp_vec());
            end
            if (state == 2'b10) begin seen = 1; in2++; end
            else if (seen) break;
        end
        delay = 1'b0;
        tests++;
        if (in2 != 2 * dwell[2] * CLK_DIV || state !== 2'b11) begin
            fails++;
            $display("FAIL ext_len got=%0d/state%b want=%0d/state11",
                     in2, state, 2 * dwell[2] * CLK_DIV);
        end
        $display("[TB] extended side green lasted %0d clocks", in2);
    endtask

    task automatic test_car();
        logic [5:0] seen_c;
        car_raw = 1'b1;
        step();
        car_raw = 1'b0;
        seen_c = '0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step();
            seen_c[i] = c;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL car_vec got=%b want=%b", dut_vec(), exp_vec());
            end
        end
        // sample 0 is one clock after the sensor was captured; c shows at sample 1
        tests++;
        if (seen_c !== 6'b000010) begin
            fails++;
            $display("FAIL car_pulse got=%b want=000010", seen_c);
        end
        car_raw = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            tests++;
            if (dut_vec() !== exp_vec() || (i >= 1 && c !== 1'b1)) begin
                fails++;
                $display("FAIL car_hold i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        car_raw = 1'b0;
        $display("[TB] car pulse trace %b", seen_c);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            mode    = ($urandom_range(0, 3) != 0);
            delay   = ($urandom_range(0, 4) == 0);
            car_raw = $urandom_range(0, 1) != 0;
            step();
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL random i=%0d got=%b want=%b", i, dut_vec(), exp_vec());
            end
        end
        mode = 1'b1; delay = 1'b0; car_raw = 1'b0;
        $display("[TB] random run done, %0d failed so far", fails);
    endtask

    task automatic test_reset_mid();
        int n;
        mode = 1'b1; delay = 1'b0; car_raw = 1'b1;
        n = 0;
        while (!(m_phase == 1 && m_elapsed == 1) && n < 300) begin step(); n++; end
        tests++;
        if (n >= 300) begin
            fails++;
            $display("FAIL midrst_wait got=timeout want=phase01_cnt1");
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        tests++;
        if (dut_vec() !== exp_vec()) begin
            fails++;
            $display("FAIL midrst_async got=%b want=%b", dut_vec(), exp_vec());
        end
        car_raw = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (state == 2'b00 && n < 60) begin
            step(); n++;
            tests++;
            if (dut_vec() !== exp_vec()) begin
                fails++;
                $display("FAIL midrst_vec got=%b want=%b", dut_vec(), exp_vec());
            end
        end
        tests++;
        if (n != dwell[0] * CLK_DIV) begin
            fails++;
            $display("FAIL midrst_len got=%0d want=%0d", n, dwell[0] * CLK_DIV);
        end
        $display("[TB] after mid-phase reset, phase 00 lasted %0d clocks", n);
    endtask

    initial begin
        test_reset();
        test_normal_cycle();
        test_hold();
        test_extension();
        test_car();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
